id_pipe_fwd: RTL and testbench
==============================

Name: id_pipe_fwd

Overview:
- Next-generation instruction-decode stage for the 5-stage MIPS core.
- Decodes the logic/shift subset: ORI, ANDI, XORI, LUI, SPECIAL AND/OR/XOR/NOR/SLL/SRL/SRA.
- Resolves operands with EX/MEM forwarding and detects load-use hazards.
- Holds the result in a registered ID/EX slot with a valid/ready handshake, sitting between IF/ID and EX.

Parameters:
- DATA_W, 32, operand/result width (must be >= 32).
- PC_W, 32, program-counter width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- flush_i  in  1  discard held slot and any HALT
- in_valid  in  1  IF/ID has an instruction
- in_ready  out  1  instruction accepted this cycle when in_valid&in_ready
- pc_i  in  PC_W  instruction PC
- inst_i  in  32  instruction word
- reg1_read_o  out  1  regfile port 1 enable
- reg1_addr_o  out  5  regfile port 1 address
- reg2_read_o  out  1  regfile port 2 enable
- reg2_addr_o  out  5  regfile port 2 address
- reg1_data_i  in  DATA_W  regfile port 1 data (same-cycle)
- reg2_data_i  in  DATA_W  regfile port 2 data (same-cycle)
- ex_wreg_i  in  1  EX writes a register
- ex_wd_i  in  5  EX destination
- ex_wdata_i  in  DATA_W  EX result
- ex_is_load_i  in  1  EX instruction is a load (data not yet available)
- mem_wreg_i  in  1  MEM writes a register
- mem_wd_i  in  5  MEM destination
- mem_wdata_i  in  DATA_W  MEM result
- out_valid  out  1  ID/EX slot holds an instruction
- out_ready  in  1  EX consumes the slot
- aluop_o  out  8  ALU sub-op
- alusel_o  out  3  ALU result class
- reg1_o  out  DATA_W  operand 1
- reg2_o  out  DATA_W  operand 2
- wd_o  out  5  destination register
- wreg_o  out  1  write enable
- pc_o  out  PC_W  PC of slot
- exc_o  out  1  invalid-instruction exception (only with the optional feature)

Behaviour:
- Decode is combinational on inst_i; register-read outputs are combinational.
- Opcodes:
  - ORI=001101, ANDI=001100, XORI=001110: rs read, imm zero-extended, wd=rt.
  - LUI=001111: aluop OR, reg1=0 (no read), imm={inst[15:0],16'h0} zero-extended, wd=rt.
  - SPECIAL=000000 with shamt==0:
    - funct 100100/100101/100110/100111 -> AND/OR/XOR/NOR, reads rs and rt, wd=rd.
  - SPECIAL with rs==0:
    - funct 000000/000010/000011 -> SLL/SRL/SRA.
    - reg1 = zero-extended shamt (no read), reg2=rt, wd=rd.
  - inst_i==0: valid NOP, wreg=0.
- Encodings:
  - aluop: AND 00100100, OR 00100101, XOR 00100110, NOR 00100111, SLL 01111100, SRL 00000010, SRA 00000011, NOP 00000000.
  - alusel: LOGIC 001, SHIFT 010, NOP 000.
- Operand select, per port:
  - If read disabled: immediate, or 0 where stated.
  - Else if addr==0: 0.
  - Else if ex_wreg_i && ex_wd_i==addr: ex_wdata_i.
  - Else if mem_wreg_i && mem_wd_i==addr: mem_wdata_i.
  - Else: regfile data.
  - EX has priority over MEM.
- Load-use stall = in_valid && ex_is_load_i && ex_wreg_i && ex_wd_i!=0 && (read port enabled with addr==ex_wd_i).
- in_ready = (!out_valid || out_ready) && !stall && state==RUN && !flush_i.
- Slot update:
  - On accept: load all outputs and set out_valid=1.
  - Else if out_ready: out_valid=0 (a stall therefore yields a bubble).
  - flush_i clears out_valid next cycle, with priority over accept.
- Reset: out_valid=0, aluop/alusel/wd/wreg=0, reg1_o/reg2_o/pc_o=0, exc_o=0, state=RUN.
- Latency: exactly 1 cycle from accept to out_valid.
- Held slot outputs are stable while out_valid && !out_ready.

Optional Feature:
- ID_INVALID_TRAP_EN defined: an accepted invalid encoding loads a NOP slot with exc_o=1 and enters HALT.
  - HALT forces in_ready=0 until flush_i; flush_i returns state to RUN and clears exc_o.
- Undefined: invalid encodings decode as NOP (wreg=0), exc_o tied 0, there is no HALT state.

Test Plan:
- ORI $2,$1,0x00FF with reg1_data=0x12340000, no forwarding -> next cycle out_valid=1, aluop=00100101, alusel=001, reg1_o=0x12340000, reg2_o=0x000000FF, wd=2, wreg=1.
- OR $3,$1,$2 with ex_wreg=1, ex_wd=1, ex_wdata=0xA; mem_wreg=1, mem_wd=1, mem_wdata=0xB -> reg1_o=0xA (EX priority); with rs=$0 -> reg1_o=0.
- Load-use: ex_is_load=1, ex_wd=5, inst ANDI $6,$5,1 -> in_ready=0 for the cycle, bubble (out_valid=0 after EX consumes), accepted next cycle once ex_is_load=0.
- Backpressure: out_ready=0 for 3 cycles with a full slot -> in_ready=0, outputs unchanged, then drain on out_ready=1.
- flush_i asserted with a full slot and in_valid=1 -> out_valid=0 next cycle, no accept.
- With ID_INVALID_TRAP_EN, inst 0xFC000000 -> exc_o=1, in_ready=0 until flush_i, then RUN. Without it -> NOP slot, exc_o=0.

Source files
------------

// File: rtl/id_pipe_fwd_if.sv
// ID/EX slot bus: registered decode result with a valid/ready handshake.
// The master side (decode stage) drives the slot; the slave side (EX) returns out_ready.
interface id_pipe_fwd_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
) ();
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        aluop_o;
  logic [2:0]        alusel_o;
  logic [DATA_W-1:0] reg1_o;
  logic [DATA_W-1:0] reg2_o;
  logic [4:0]        wd_o;
  logic              wreg_o;
  logic [PC_W-1:0]   pc_o;
  logic              exc_o;

  modport master (
    output out_valid, aluop_o, alusel_o, reg1_o, reg2_o, wd_o, wreg_o, pc_o, exc_o,
    input  out_ready
  );

  modport slave (
    input  out_valid, aluop_o, alusel_o, reg1_o, reg2_o, wd_o, wreg_o, pc_o, exc_o,
    output out_ready
  );
endinterface

// File: rtl/id_pipe_fwd.sv
// Decode stage for the logic/shift subset with EX/MEM forwarding, load-use stall and a
// registered ID/EX slot. Define ID_INVALID_TRAP_EN to trap invalid encodings into HALT.
module id_pipe_fwd #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [31:0]       inst_i,
  output logic              reg1_read_o,
  output logic [4:0]        reg1_addr_o,
  output logic              reg2_read_o,
  output logic [4:0]        reg2_addr_o,
  input  logic [DATA_W-1:0] reg1_data_i,
  input  logic [DATA_W-1:0] reg2_data_i,
  input  logic              ex_wreg_i,
  input  logic [4:0]        ex_wd_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  input  logic              ex_is_load_i,
  input  logic              mem_wreg_i,
  input  logic [4:0]        mem_wd_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  id_pipe_fwd_if.master     id_ex
);

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] F_SLL      = 6'b000000;
  localparam logic [5:0] F_SRL      = 6'b000010;
  localparam logic [5:0] F_SRA      = 6'b000011;

  localparam logic [7:0] ALU_NOP = 8'b00000000;
  localparam logic [7:0] ALU_AND = 8'b00100100;
  localparam logic [7:0] ALU_OR  = 8'b00100101;
  localparam logic [7:0] ALU_XOR = 8'b00100110;
  localparam logic [7:0] ALU_NOR = 8'b00100111;
  localparam logic [7:0] ALU_SLL = 8'b01111100;
  localparam logic [7:0] ALU_SRL = 8'b00000010;
  localparam logic [7:0] ALU_SRA = 8'b00000011;

  localparam logic [2:0] SEL_NOP   = 3'b000;
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;

  assign op    = inst_i[31:26];
  assign rs    = inst_i[25:21];
  assign rt    = inst_i[20:16];
  assign rd    = inst_i[15:11];
  assign shamt = inst_i[10:6];
  assign funct = inst_i[5:0];
  assign imm   = inst_i[15:0];

  logic [7:0]        dec_aluop;
  logic [2:0]        dec_alusel;
  logic [4:0]        dec_wd;
  logic              dec_wreg;
  logic [DATA_W-1:0] dec_imm1, dec_imm2;

  always_comb begin
    reg1_read_o = 1'b0;
    reg2_read_o = 1'b0;
    reg1_addr_o = rs;
    reg2_addr_o = rt;
    dec_imm1    = '0;
    dec_imm2    = '0;
    dec_aluop   = ALU_NOP;
    dec_alusel  = SEL_NOP;
    dec_wd      = '0;
    dec_wreg    = 1'b0;
    if (inst_i != '0) begin
      case (op)
        OP_ORI, OP_ANDI, OP_XORI: begin
          reg1_read_o = 1'b1;
          dec_imm2    = DATA_W'(imm);
          dec_alusel  = SEL_LOGIC;
          dec_wd      = rt;
          dec_wreg    = 1'b1;
          case (op)
            OP_ANDI: dec_aluop = ALU_AND;
            OP_XORI: dec_aluop = ALU_XOR;
            default: dec_aluop = ALU_OR;
          endcase
        end
        OP_LUI: begin
          dec_imm2   = DATA_W'({imm, 16'h0000});
          dec_aluop  = ALU_OR;
          dec_alusel = SEL_LOGIC;
          dec_wd     = rt;
          dec_wreg   = 1'b1;
        end
        OP_SPECIAL: begin
          if (shamt == '0 && funct[5:2] == 4'b1001) begin
            reg1_read_o = 1'b1;
            reg2_read_o = 1'b1;
            dec_alusel  = SEL_LOGIC;
            dec_wd      = rd;
            dec_wreg    = 1'b1;
            case (funct[1:0])
              2'b00:   dec_aluop = ALU_AND;
              2'b01:   dec_aluop = ALU_OR;
              2'b10:   dec_aluop = ALU_XOR;
              default: dec_aluop = ALU_NOR;
            endcase
          end else if (rs == '0 && (funct == F_SLL || funct == F_SRL || funct == F_SRA)) begin
            reg2_read_o = 1'b1;
            dec_imm1    = DATA_W'(shamt);
            dec_alusel  = SEL_SHIFT;
            dec_wd      = rd;
            dec_wreg    = 1'b1;
            case (funct)
              F_SRL:   dec_aluop = ALU_SRL;
              F_SRA:   dec_aluop = ALU_SRA;
              default: dec_aluop = ALU_SLL;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  // EX result wins over MEM: it is the younger producer of the same register.
  function automatic logic [DATA_W-1:0] resolve(
    input logic rd_en, input logic [4:0] addr,
    input logic [DATA_W-1:0] imm_v, input logic [DATA_W-1:0] rf_data,
    input logic ex_w, input logic [4:0] ex_a, input logic [DATA_W-1:0] ex_d,
    input logic mem_w, input logic [4:0] mem_a, input logic [DATA_W-1:0] mem_d);
    if (!rd_en)                    return imm_v;
    else if (addr == '0)           return '0;
    else if (ex_w && ex_a == addr) return ex_d;
    else if (mem_w && mem_a == addr) return mem_d;
    else                           return rf_data;
  endfunction

  logic [DATA_W-1:0] op1, op2;
  logic              stall, accept, run;

  assign op1 = resolve(reg1_read_o, rs, dec_imm1, reg1_data_i, ex_wreg_i, ex_wd_i, ex_wdata_i,
                       mem_wreg_i, mem_wd_i, mem_wdata_i);
  assign op2 = resolve(reg2_read_o, rt, dec_imm2, reg2_data_i, ex_wreg_i, ex_wd_i, ex_wdata_i,
                       mem_wreg_i, mem_wd_i, mem_wdata_i);

  assign stall = in_valid && ex_is_load_i && ex_wreg_i && (ex_wd_i != '0) &&
                 ((reg1_read_o && rs == ex_wd_i) || (reg2_read_o && rt == ex_wd_i));

  logic valid_q;
  assign in_ready = (!valid_q || id_ex.out_ready) && !stall && run && !flush_i;
  assign accept   = in_valid && in_ready;

`ifdef ID_INVALID_TRAP_EN
  typedef enum logic {ST_RUN, ST_HALT} state_e;
  state_e state_q, state_d;
  logic   exc_q, exc_d, dec_bad;

  // Every valid non-NOP encoding writes a register, so a nonzero word with no write is invalid.
  assign dec_bad = (inst_i != '0) && !dec_wreg;

  always_comb begin
    state_d = state_q;
    exc_d   = exc_q;
    if (flush_i) begin
      state_d = ST_RUN;
      exc_d   = 1'b0;
    end else if (accept) begin
      exc_d = dec_bad;
      if (dec_bad) state_d = ST_HALT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      exc_q   <= exc_d;
    end
  end

  assign run         = (state_q == ST_RUN);
  assign id_ex.exc_o = exc_q;
`else
  assign run         = 1'b1;
  assign id_ex.exc_o = 1'b0;
`endif

  logic              valid_d, wreg_q, wreg_d;
  logic [7:0]        aluop_q, aluop_d;
  logic [2:0]        alusel_q, alusel_d;
  logic [4:0]        wd_q, wd_d;
  logic [DATA_W-1:0] reg1_q, reg1_d, reg2_q, reg2_d;
  logic [PC_W-1:0]   pc_q, pc_d;

  always_comb begin
    valid_d  = valid_q;
    aluop_d  = aluop_q;
    alusel_d = alusel_q;
    wd_d     = wd_q;
    wreg_d   = wreg_q;
    reg1_d   = reg1_q;
    reg2_d   = reg2_q;
    pc_d     = pc_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d  = 1'b1;
      aluop_d  = dec_aluop;
      alusel_d = dec_alusel;
      wd_d     = dec_wd;
      wreg_d   = dec_wreg;
      reg1_d   = op1;
      reg2_d   = op2;
      pc_d     = pc_i;
    end else if (id_ex.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      aluop_q  <= '0;
      alusel_q <= '0;
      wd_q     <= '0;
      wreg_q   <= 1'b0;
      reg1_q   <= '0;
      reg2_q   <= '0;
      pc_q     <= '0;
    end else begin
      valid_q  <= valid_d;
      aluop_q  <= aluop_d;
      alusel_q <= alusel_d;
      wd_q     <= wd_d;
      wreg_q   <= wreg_d;
      reg1_q   <= reg1_d;
      reg2_q   <= reg2_d;
      pc_q     <= pc_d;
    end
  end

  assign id_ex.out_valid = valid_q;
  assign id_ex.aluop_o   = aluop_q;
  assign id_ex.alusel_o  = alusel_q;
  assign id_ex.wd_o      = wd_q;
  assign id_ex.wreg_o    = wreg_q;
  assign id_ex.reg1_o    = reg1_q;
  assign id_ex.reg2_o    = reg2_q;
  assign id_ex.pc_o      = pc_q;

endmodule

// File: tb/tb_id_pipe_fwd.sv
// Scoreboard bench for id_pipe_fwd: a mnemonic-level reference predicts each accepted slot,
// and a negedge monitor compares the presented ID/EX slot against the queue head.
module tb_id_pipe_fwd;
  localparam int DATA_W = 32;
  localparam int PC_W   = 32;

`ifdef ID_INVALID_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic flush_i, in_valid, in_ready;
  logic [PC_W-1:0] pc_i;
  logic [31:0] inst_i;
  logic reg1_read_o, reg2_read_o;
  logic [4:0] reg1_addr_o, reg2_addr_o;
  logic [DATA_W-1:0] reg1_data_i, reg2_data_i;
  logic ex_wreg_i, ex_is_load_i, mem_wreg_i;
  logic [4:0] ex_wd_i, mem_wd_i;
  logic [DATA_W-1:0] ex_wdata_i, mem_wdata_i;
  logic [DATA_W-1:0] rf [32];

  id_pipe_fwd_if #(.DATA_W(DATA_W), .PC_W(PC_W)) bus ();

  id_pipe_fwd #(.DATA_W(DATA_W), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .in_valid(in_valid), .in_ready(in_ready),
    .pc_i(pc_i), .inst_i(inst_i),
    .reg1_read_o(reg1_read_o), .reg1_addr_o(reg1_addr_o),
    .reg2_read_o(reg2_read_o), .reg2_addr_o(reg2_addr_o),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i), .ex_is_load_i(ex_is_load_i),
    .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
    .id_ex(bus)
  );

  always #5 clk = ~clk;

  // Register file model answers whatever address the DUT presents.
  assign reg1_data_i = rf[reg1_addr_o];
  assign reg2_data_i = rf[reg2_addr_o];

  typedef struct {
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] pc;
    logic        exc;
  } slot_t;

  slot_t q[$];
  slot_t mon_e;
  int    errors = 0;
  int    checks = 0;
  bit    mon_en = 1'b0;
  bit    m_valid = 1'b0;
  bit    m_halt  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic string mnem(input logic [31:0] ins);
    logic [5:0] op, fn;
    logic [4:0] rs, sh;
    op = ins[31:26]; fn = ins[5:0]; rs = ins[25:21]; sh = ins[10:6];
    if (ins == 32'h0) return "NOP";
    if (op == 6'h0D) return "ORI";
    if (op == 6'h0C) return "ANDI";
    if (op == 6'h0E) return "XORI";
    if (op == 6'h0F) return "LUI";
    if (op == 6'h00) begin
      if (sh == 5'd0 && fn == 6'h24) return "AND";
      if (sh == 5'd0 && fn == 6'h25) return "OR";
      if (sh == 5'd0 && fn == 6'h26) return "XOR";
      if (sh == 5'd0 && fn == 6'h27) return "NOR";
      if (rs == 5'd0 && fn == 6'h00) return "SLL";
      if (rs == 5'd0 && fn == 6'h02) return "SRL";
      if (rs == 5'd0 && fn == 6'h03) return "SRA";
    end
    return "BAD";
  endfunction

  function automatic logic [31:0] operand(input bit en, input logic [4:0] a, input logic [31:0] imm);
    if (!en) return imm;
    if (a == 5'd0) return 32'h0;
    if (ex_wreg_i && ex_wd_i == a) return ex_wdata_i;
    if (mem_wreg_i && mem_wd_i == a) return mem_wdata_i;
    return rf[a];
  endfunction

  // Runs mid-cycle with this cycle's inputs settled: predicts acceptance and the resulting slot.
  task automatic predict();
    string m;
    bit r1en, r2en, wr, bad, stall, exp_ready, acc;
    logic [31:0] i1, i2;
    logic [7:0] aop;
    logic [2:0] asel;
    logic [4:0] rs, rt, rd, wd;
    slot_t s;
    m = mnem(inst_i);
    rs = inst_i[25:21]; rt = inst_i[20:16]; rd = inst_i[15:11];
    r1en = 0; r2en = 0; wr = 0; bad = 0; i1 = 0; i2 = 0; aop = 0; asel = 0; wd = 0;
    if (m == "ORI" || m == "ANDI" || m == "XORI") begin
      r1en = 1; i2 = {16'h0, inst_i[15:0]}; asel = 3'd1; wd = rt; wr = 1;
      aop = (m == "ORI") ? 8'h25 : (m == "ANDI") ? 8'h24 : 8'h26;
    end else if (m == "LUI") begin
      i2 = {inst_i[15:0], 16'h0}; aop = 8'h25; asel = 3'd1; wd = rt; wr = 1;
    end else if (m == "AND" || m == "OR" || m == "XOR" || m == "NOR") begin
      r1en = 1; r2en = 1; asel = 3'd1; wd = rd; wr = 1;
      aop = (m == "AND") ? 8'h24 : (m == "OR") ? 8'h25 : (m == "XOR") ? 8'h26 : 8'h27;
    end else if (m == "SLL" || m == "SRL" || m == "SRA") begin
      r2en = 1; i1 = {27'h0, inst_i[10:6]}; asel = 3'd2; wd = rd; wr = 1;
      aop = (m == "SLL") ? 8'h7C : (m == "SRL") ? 8'h02 : 8'h03;
    end else if (m == "BAD") begin
      bad = 1;
    end
    stall = in_valid && ex_is_load_i && ex_wreg_i && ex_wd_i != 5'd0 &&
            ((r1en && rs == ex_wd_i) || (r2en && rt == ex_wd_i));
    exp_ready = (!m_valid || bus.out_ready) && !stall && !m_halt && !flush_i;
    chk("in_ready", in_ready, exp_ready);
    chk("reg1_read", reg1_read_o, r1en);
    chk("reg2_read", reg2_read_o, r2en);
    if (r1en) chk("reg1_addr", reg1_addr_o, rs);
    if (r2en) chk("reg2_addr", reg2_addr_o, rt);
    acc = in_valid && exp_ready;
    if (acc) begin
      s.aluop = aop; s.alusel = asel; s.wd = wd; s.wreg = wr; s.pc = pc_i;
      s.r1 = operand(r1en, rs, i1);
      s.r2 = operand(r2en, rt, i2);
      s.exc = TRAP && bad;
      q.push_back(s);
    end
    if (flush_i) m_valid = 0;
    else if (acc) m_valid = 1;
    else if (bus.out_ready) m_valid = 0;
    if (flush_i) m_halt = 0;
    else if (acc && bad && TRAP) m_halt = 1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", bus.out_valid, q.size() != 0);
      if (q.size() != 0) begin
        mon_e = q[0];
        chk("aluop", bus.aluop_o, mon_e.aluop);
        chk("alusel", bus.alusel_o, mon_e.alusel);
        chk("reg1", bus.reg1_o, mon_e.r1);
        chk("reg2", bus.reg2_o, mon_e.r2);
        chk("wd", bus.wd_o, mon_e.wd);
        chk("wreg", bus.wreg_o, mon_e.wreg);
        chk("pc", bus.pc_o, mon_e.pc);
        chk("exc", bus.exc_o, mon_e.exc);
        if (bus.out_ready || flush_i) void'(q.pop_front());
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1 predict();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    ex_wreg_i = 0; ex_wd_i = 0; ex_wdata_i = 0; ex_is_load_i = 0;
    mem_wreg_i = 0; mem_wd_i = 0; mem_wdata_i = 0; flush_i = 0;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [4:0] a, b, c, sh;
    logic [5:0] fn;
    int k, s;
    k = $urandom_range(0, 9);
    a = 5'($urandom_range(0, 7)); b = 5'($urandom_range(0, 7));
    c = 5'($urandom_range(0, 7)); sh = 5'($urandom);
    case (k)
      0: return {6'h0D, a, b, 16'($urandom)};
      1: return {6'h0C, a, b, 16'($urandom)};
      2: return {6'h0E, a, b, 16'($urandom)};
      3: return {6'h0F, 5'd0, b, 16'($urandom)};
      4: begin fn = 6'h24 | 6'($urandom_range(0, 3)); return {6'h00, a, b, c, 5'd0, fn}; end
      5: begin
        s = $urandom_range(0, 2);
        fn = (s == 0) ? 6'h00 : (s == 1) ? 6'h02 : 6'h03;
        return {6'h00, 5'd0, b, c, sh, fn};
      end
      6: return 32'h0;
      7: return $urandom;
      8: return 32'hFC000000;
      default: return {6'h00, a, b, c, 5'd1, 6'h25};
    endcase
  endfunction

  initial begin
    rst = 1; in_valid = 0; inst_i = 0; pc_i = 0; bus.out_ready = 0;
    quiet();
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_aluop", bus.aluop_o, 0);
    chk("rst_alusel", bus.alusel_o, 0);
    chk("rst_wd", bus.wd_o, 0);
    chk("rst_wreg", bus.wreg_o, 0);
    chk("rst_reg1", bus.reg1_o, 0);
    chk("rst_reg2", bus.reg2_o, 0);
    chk("rst_pc", bus.pc_o, 0);
    chk("rst_exc", bus.exc_o, 0);
    chk("rst_in_ready", in_ready, 1);
    mon_en = 1;
    @(posedge clk);
    #1;

    // ORI $2,$1,0x00FF, no forwarding
    rf[1] = 32'h12340000; bus.out_ready = 1; in_valid = 1; pc_i = 32'h100;
    inst_i = {6'h0D, 5'd1, 5'd2, 16'h00FF};
    step();
    // OR $3,$1,$2 with EX and MEM both producing $1
    ex_wreg_i = 1; ex_wd_i = 1; ex_wdata_i = 32'hA;
    mem_wreg_i = 1; mem_wd_i = 1; mem_wdata_i = 32'hB;
    inst_i = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h25}; pc_i = 32'h104;
    step();
    inst_i = {6'h00, 5'd0, 5'd2, 5'd3, 5'd0, 6'h25}; pc_i = 32'h108;
    step();
    // load-use on $5
    quiet();
    ex_is_load_i = 1; ex_wreg_i = 1; ex_wd_i = 5;
    inst_i = {6'h0C, 5'd5, 5'd6, 16'h0001}; pc_i = 32'h10C;
    step();
    quiet();
    step();
    // backpressure with a full slot
    inst_i = {6'h0E, 5'd3, 5'd4, 16'h5A5A}; pc_i = 32'h110;
    step();
    bus.out_ready = 0; inst_i = {6'h0F, 5'd0, 5'd7, 16'hBEEF}; pc_i = 32'h114;
    repeat (3) step();
    bus.out_ready = 1;
    repeat (2) step();
    // flush with a full slot and a pending instruction
    bus.out_ready = 0; inst_i = {6'h00, 5'd0, 5'd4, 5'd5, 5'd3, 6'h03}; pc_i = 32'h118;
    step();
    flush_i = 1;
    step();
    flush_i = 0; in_valid = 0;
    step();
    // invalid encoding
    bus.out_ready = 1; in_valid = 1; inst_i = 32'hFC000000; pc_i = 32'h11C;
    step();
    inst_i = {6'h0D, 5'd1, 5'd2, 16'h0003}; pc_i = 32'h120;
    repeat (3) step();
    flush_i = 1;
    step();
    flush_i = 0;
    step();

    for (int i = 0; i < 1500; i++) begin
      in_valid = ($urandom % 4) != 0;
      inst_i = rand_inst();
      pc_i = $urandom;
      ex_wreg_i = $urandom % 2; ex_wd_i = 5'($urandom_range(0, 7)); ex_wdata_i = $urandom;
      ex_is_load_i = ($urandom % 5) == 0;
      mem_wreg_i = $urandom % 2; mem_wd_i = 5'($urandom_range(0, 7)); mem_wdata_i = $urandom;
      bus.out_ready = ($urandom % 10) < 7;
      flush_i = ($urandom % 20) == 0;
      rf[$urandom_range(0, 7)] = $urandom;
      step();
    end

    quiet(); in_valid = 0; bus.out_ready = 1;
    repeat (3) step();
    chk("drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
